posit_batch_sequencer: RTL and testbench

POSIT_BATCH_SEQUENCER -- requirements
Module: posit_batch_sequencer

---
 rtl/posit_batch_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_posit_batch_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_batch_sequencer.sv
// -----------------------------------------------------------------------------
// posit_batch_sequencer
//
// Purpose: walks a batch of posit jobs held in shared on-chip memory. For each
// job it presents the operand-pair address and the result address to a
// downstream posit core. It then raises core_start and waits for the core's
// completion level to rise and fall. After that it advances both addresses by
// their strides. A one-cycle done pulse marks the end of the batch.
//
// Optional feature (macro POSIT_BATCH_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts the cycles spent waiting in
//   ISSUE or RELEASE. If it reaches TIMEOUT_CYCLES, the batch is abandoned
//   through FINISH and the sticky error flag is set. When the macro is not
//   defined, there is no counter and error is tied low.
//
// Ports:
//   clock                  in   sole clock, rising edge
//   reset                  in   synchronous, active-high
//   cmd_valid / cmd_ready  in/out  batch command handshake (ready only in IDLE)
//   cmd_src_base           in   first operand-pair byte address
//   cmd_dst_base           in   first result byte address
//   cmd_count              in   number of jobs (0 => immediate done)
//   core_start             out  start level to the posit core
//   core_starting_address  out  operand address of the current job
//   core_result_address    out  result address of the current job
//   core_completed         in   completion level from the posit core
//   busy                   out  high whenever not IDLE
//   done                   out  one-cycle pulse at batch end
//   done_count             out  jobs completed in the current/last batch
//   error                  out  sticky watchdog flag
// -----------------------------------------------------------------------------
module posit_batch_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int CNT_W          = 8,
  parameter int SRC_STRIDE     = 8,
  parameter int DST_STRIDE     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src_base,
  input  logic [ADDR_W-1:0] cmd_dst_base,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_starting_address,
  output logic [ADDR_W-1:0] core_result_address,
  input  logic              core_completed,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  done_count,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RELEASE,
    NEXT,
    FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] SRC_INC = ADDR_W'(SRC_STRIDE);
  localparam logic [ADDR_W-1:0] DST_INC = ADDR_W'(DST_STRIDE);

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_done_count;
  logic [CNT_W-1:0]   w_remaining_dec;
  logic               w_timeout;

  assign w_remaining_dec       = r_remaining - CNT_W'(1);
  assign core_starting_address = r_src;
  assign core_result_address   = r_dst;
  assign done_count            = r_done_count;

  // Next-state and Moore outputs
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    core_start   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_state_next = (cmd_count != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        // A completion seen on the same cycle as the watchdog expiry wins.
        if (core_completed) begin
          w_state_next = RELEASE;
        end else if (w_timeout) begin
          w_state_next = FINISH;
        end
      end
      RELEASE: begin
        if (!core_completed) begin
          w_state_next = NEXT;
        end else if (w_timeout) begin
          w_state_next = FINISH;
        end
      end
      NEXT: begin
        w_state_next = (w_remaining_dec != '0) ? ISSUE : FINISH;
      end
      FINISH: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register and job datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_remaining  <= '0;
      r_done_count <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_src        <= cmd_src_base;
            r_dst        <= cmd_dst_base;
            r_remaining  <= cmd_count;
            r_done_count <= '0;
          end
        end
        ISSUE: begin
          // Counting on the ISSUE->RELEASE edge makes the increment happen
          // exactly once per job, visible from the first RELEASE cycle.
          if (core_completed) begin
            r_done_count <= r_done_count + CNT_W'(1);
          end
        end
        NEXT: begin
          // Address arithmetic wraps naturally at 2^ADDR_W.
          r_src       <= r_src + SRC_INC;
          r_dst       <= r_dst + DST_INC;
          r_remaining <= w_remaining_dec;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef POSIT_BATCH_TIMEOUT_EN
  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_timer;
  logic             r_error;
  logic             w_waiting;

  assign w_waiting = (r_state == ISSUE) || (r_state == RELEASE);
  // The timer is zero on the first cycle of a state. It therefore reads
  // TIMEOUT_CYCLES-1 on the last permitted waiting cycle.
  assign w_timeout = w_waiting && (r_timer == TMR_LAST);
  assign error     = r_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= '0;
      r_error <= 1'b0;
    end else begin
      if (!w_waiting || (w_state_next != r_state)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if ((r_state == IDLE) && cmd_valid) begin
        r_error <= 1'b0;
      end else if (w_waiting && (w_state_next == FINISH)) begin
        r_error <= 1'b1;
      end
    end
  end
`else
  // No watchdog: waits are unbounded. This compare is always false, so error
  // stays constant low. TIMEOUT_CYCLES is still referenced here so the
  // parameter is not left unused.
  assign w_timeout = 1'b0;
  assign error     = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_posit_batch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_posit_batch_sequencer
//
// Self-checking bench for posit_batch_sequencer. A simple core model raises
// core_completed 5 cycles after core_start. It drops core_completed once
// core_start falls. Each accepted command pushes its expected job addresses
// into a queue. The monitor pops one entry on every core_start rising edge
// and compares the presented addresses against it.
// The timeout scenario is built only when POSIT_BATCH_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_posit_batch_sequencer;

  typedef struct {
    logic [11:0] src;
    logic [11:0] dst;
  } job_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_src_base = '0;
  logic [11:0] cmd_dst_base = '0;
  logic [7:0]  cmd_count = '0;
  logic        core_start;
  logic [11:0] core_starting_address;
  logic [11:0] core_result_address;
  logic        core_completed = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  done_count;
  logic        error;

  posit_batch_sequencer #(
    .ADDR_W         (12),
    .CNT_W          (8),
    .SRC_STRIDE     (8),
    .DST_STRIDE     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_src_base          (cmd_src_base),
    .cmd_dst_base          (cmd_dst_base),
    .cmd_count             (cmd_count),
    .core_start            (core_start),
    .core_starting_address (core_starting_address),
    .core_result_address   (core_result_address),
    .core_completed        (core_completed),
    .busy                  (busy),
    .done                  (done),
    .done_count            (done_count),
    .error                 (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Core model: completion 5 cycles after start; held until start drops.
  logic       core_stuck = 1'b0;
  logic [2:0] core_cnt = '0;
  always @(posedge clock) begin
    if (reset || !core_start) begin
      core_cnt       <= '0;
      core_completed <= 1'b0;
    end else if (!core_stuck) begin
      if (core_cnt == 3'd4) core_completed <= 1'b1;
      else                  core_cnt <= core_cnt + 3'd1;
    end
  end

  // Scoreboard and monitor
  job_t        sb_q[$];
  int          start_rises = 0;
  int          start_cycles = 0;
  int          done_pulses = 0;
  int          last_done_cyc = 0;
  logic [7:0]  last_done_count = '0;
  logic        last_done_err = 1'b0;
  logic        last_done_start = 1'b0;
  logic        prev_start = 1'b0;
  logic        prev_done = 1'b0;
  logic [11:0] prev_src = '0;
  logic [11:0] prev_dst = '0;

  always @(negedge clock) begin
    job_t e;
    if (!reset) begin
      if (core_start && !prev_start) begin
        start_rises++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL job_start: unexpected start src=%h dst=%h, required no start",
                   core_starting_address, core_result_address);
        end else begin
          e = sb_q.pop_front();
          if (core_starting_address !== e.src || core_result_address !== e.dst) begin
            n_fail++;
            $display("FAIL job_addr: got src=%h dst=%h, required src=%h dst=%h",
                     core_starting_address, core_result_address, e.src, e.dst);
          end else begin
            $display("job start src=%h dst=%h", core_starting_address, core_result_address);
          end
        end
      end
      if (core_start && prev_start) begin
        n_checks++;
        if (core_starting_address !== prev_src || core_result_address !== prev_dst) begin
          n_fail++;
          $display("FAIL addr_stable: got %h/%h, required %h/%h during ISSUE",
                   core_starting_address, core_result_address, prev_src, prev_dst);
        end
      end
      if (core_start) start_cycles++;
      if (done) begin
        done_pulses++;
        last_done_cyc   = cyc;
        last_done_count = done_count;
        last_done_err   = error;
        last_done_start = core_start;
        n_checks++;
        if (prev_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_width: done high on consecutive cycles, required one-cycle pulse");
        end
      end
    end
    prev_start = core_start;
    prev_done  = done;
    prev_src   = core_starting_address;
    prev_dst   = core_result_address;
  end

  // Drive a command and wait (bounded) for acceptance. acc_cyc is the value of
  // cyc in the cycle right after the acceptance edge (-1 if never accepted).
  task automatic send_cmd(input logic [11:0] src, input logic [11:0] dst,
                          input logic [7:0] cnt, input bit drop_valid,
                          output int acc_cyc);
    job_t e;
    @(negedge clock);
    cmd_src_base = src;
    cmd_dst_base = dst;
    cmd_count    = cnt;
    cmd_valid    = 1'b1;
    acc_cyc      = -1;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready === 1'b1) begin
        acc_cyc = 0;
        break;
      end
      @(negedge clock);
    end
    n_checks++;
    if (acc_cyc < 0) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for 400 cycles, required 1");
      cmd_valid = 1'b0;
      return;
    end
    for (int j = 0; j < int'(cnt); j++) begin
      e.src = src + 12'(j * 8);
      e.dst = dst + 12'(j * 4);
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    if (drop_valid) cmd_valid = 1'b0;
    $display("cmd accepted src=%h dst=%h count=%0d", src, dst, cnt);
  endtask

  task automatic wait_done(input int target, input int bound);
    for (int i = 0; i < bound && done_pulses < target; i++) begin
      @(negedge clock);
      #1;
    end
    n_checks++;
    if (done_pulses < target) begin
      n_fail++;
      $display("FAIL done_timeout: %0d done pulses after %0d cycles, required %0d",
               done_pulses, bound, target);
    end else begin
      $display("batch done done_count=%0d error=%0b", last_done_count, last_done_err);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b, required 0", core_start); end
    n_checks++; if (done_count !== 8'd0) begin n_fail++; $display("FAIL rst_done_count: got %0d, required 0", done_count); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b, required 0", error); end
    n_checks++; if (core_starting_address !== 12'h0 || core_result_address !== 12'h0) begin
      n_fail++; $display("FAIL rst_addr: got %h/%h, required 000/000", core_starting_address, core_result_address);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_batch();
    int acc;
    int d0 = done_pulses;
    int r0 = start_rises;
    send_cmd(12'h000, 12'h010, 8'd3, 1'b1, acc);
    @(negedge clock);
    n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL start_after_accept: got %b, required 1", core_start); end
    wait_done(d0 + 1, 200);
    n_checks++; if (start_rises - r0 != 3) begin n_fail++; $display("FAIL basic_jobs: got %0d starts, required 3", start_rises - r0); end
    n_checks++; if (last_done_count !== 8'd3) begin n_fail++; $display("FAIL basic_done_count: got %0d, required 3", last_done_count); end
    n_checks++; if (last_done_err !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b, required 0", last_done_err); end
    n_checks++; if (done_pulses - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, required 1", done_pulses - d0); end
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL basic_sb: %0d jobs missing, required 0", sb_q.size()); end
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: busy=%b ready=%b, required 0/1", busy, cmd_ready); end
  endtask

  task automatic test_zero_count();
    int acc;
    int d0 = done_pulses;
    int r0 = start_rises;
    send_cmd(12'h100, 12'h200, 8'd0, 1'b1, acc);
    @(negedge clock);
    // FINISH directly follows acceptance for an empty batch.
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_timing: got done=%b, required 1 right after acceptance", done); end
    repeat (4) @(negedge clock);
    n_checks++; if (start_rises != r0) begin n_fail++; $display("FAIL zero_no_start: got %0d starts, required 0", start_rises - r0); end
    n_checks++; if (done_pulses - d0 != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d, required 1", done_pulses - d0); end
    n_checks++; if (done_count !== 8'd0) begin n_fail++; $display("FAIL zero_done_count: got %0d, required 0", done_count); end
  endtask

  task automatic test_wrap();
    int acc;
    int d0 = done_pulses;
    send_cmd(12'hFF8, 12'hFFC, 8'd2, 1'b1, acc);
    wait_done(d0 + 1, 200);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL wrap_sb: %0d jobs missing, required 0", sb_q.size()); end
    n_checks++; if (last_done_count !== 8'd2) begin n_fail++; $display("FAIL wrap_done_count: got %0d, required 2", last_done_count); end
  endtask

  task automatic test_reset_mid_job();
    int acc;
    int i;
    int d0;
    int r0 = start_rises;
    send_cmd(12'h040, 12'h080, 8'd4, 1'b1, acc);
    for (i = 0; i < 200 && start_rises < r0 + 2; i++) @(negedge clock);
    @(negedge clock);
    n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL mid_in_issue: got start=%b, required 1 before reset", core_start); end
    d0 = done_pulses;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_start: got %b, required 0", core_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    n_checks++; if (done_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_done_count: got %0d, required 0", done_count); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b, required 1", cmd_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b, required 0", done); end
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    n_checks++; if (done_pulses != d0) begin n_fail++; $display("FAIL mid_rst_no_done: got %0d pulses, required 0", done_pulses - d0); end
    n_checks++; if (start_rises != r0 + 2) begin n_fail++; $display("FAIL mid_rst_no_restart: got %0d starts, required 2", start_rises - r0); end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc_a;
    int acc_b;
    int d0 = done_pulses;
    int d_at_b;
    send_cmd(12'h200, 12'h300, 8'd2, 1'b0, acc_a);
    @(negedge clock);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy: got %b, required 0 while busy", cmd_ready); end
    send_cmd(12'h400, 12'h500, 8'd1, 1'b1, acc_b);
    d_at_b = done_pulses;
    n_checks++; if (d_at_b - d0 != 1) begin n_fail++; $display("FAIL b2b_order: %0d pulses before second accept, required 1", d_at_b - d0); end
    n_checks++; if (acc_b != last_done_cyc + 2) begin n_fail++; $display("FAIL b2b_accept_cyc: got %0d, required %0d", acc_b, last_done_cyc + 2); end
    wait_done(d0 + 2, 200);
    n_checks++; if (last_done_count !== 8'd1) begin n_fail++; $display("FAIL b2b_done_count: got %0d, required 1", last_done_count); end
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_sb: %0d jobs missing, required 0", sb_q.size()); end
  endtask

`ifdef POSIT_BATCH_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    int d0 = done_pulses;
    int s0 = start_cycles;
    core_stuck = 1'b1;
    send_cmd(12'h010, 12'h020, 8'd2, 1'b1, acc);
    wait_done(d0 + 1, 100);
    n_checks++; if (start_cycles - s0 != 16) begin n_fail++; $display("FAIL to_issue_cycles: got %0d, required 16", start_cycles - s0); end
    n_checks++; if (last_done_err !== 1'b1) begin n_fail++; $display("FAIL to_error: got %b, required 1", last_done_err); end
    n_checks++; if (last_done_start !== 1'b0) begin n_fail++; $display("FAIL to_start_drop: got %b, required 0", last_done_start); end
    n_checks++; if (last_done_count !== 8'd0) begin n_fail++; $display("FAIL to_done_count: got %0d, required 0", last_done_count); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b, required 1", error); end
    sb_q.delete();
    core_stuck = 1'b0;
    send_cmd(12'h030, 12'h040, 8'd1, 1'b1, acc);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL to_clear_on_accept: got %b, required 0", error); end
    wait_done(d0 + 2, 100);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_batch();
    test_zero_count();
    test_wrap();
    test_reset_mid_job();
    test_back_to_back();
`ifdef POSIT_BATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
